// File: rtl/conv1_window_gen.sv
// conv1_window_gen: builds sliding 3x3 windows from a raster pixel stream.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   valid_in        input beat valid, every high cycle is accepted
//   data_in         pixel word, raster order
//   data_out[0:8]   window, row-major ([0]=top-left, [8]=bottom-right)
//   valid_out       data_out holds a new complete window (one-cycle pulse)
//   frame_done      pulses with the last window of a frame
module conv1_window_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out [0:8],
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [DATA_WIDTH-1:0] r_lb1 [0:IMG_W-1];
  logic [DATA_WIDTH-1:0] r_lb2 [0:IMG_W-1];
  logic [DATA_WIDTH-1:0] r_win [0:8];
  logic                  r_valid;
  logic                  r_frame_done;

  logic [DATA_WIDTH-1:0] w_lb1_out;
  logic [DATA_WIDTH-1:0] w_lb2_out;
  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_win_ok;

  // The column counter doubles as the line-buffer address: each slot is
  // revisited exactly IMG_W beats later, giving a one-row delay.
  assign w_lb1_out  = r_lb1[r_col];
  assign w_lb2_out  = r_lb2[r_col];
  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
  // Windows straddling a row wrap or missing rows of this frame are suppressed.
  assign w_win_ok   = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

  // Raster position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Line buffers (contents intentionally not reset)
  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_lb1[r_col] <= data_in;
      r_lb2[r_col] <= w_lb1_out;
    end
  end

  // Window shift register and output strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) r_win[k] <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid      <= valid_in && w_win_ok;
      r_frame_done <= valid_in && w_row_last && w_col_last;
      if (valid_in) begin
        for (int t = 0; t < 3; t++) begin
          r_win[3*t]   <= r_win[3*t+1];
          r_win[3*t+1] <= r_win[3*t+2];
        end
        r_win[2] <= w_lb2_out;
        r_win[5] <= w_lb1_out;
        r_win[8] <= data_in;
      end
    end
  end

  assign data_out   = r_win;
  assign valid_out  = r_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv1_window_gen.sv
module tb_conv1_window_gen;

  typedef struct packed {
    logic [287:0] w;
    logic         fd;
  } exp_t;

  typedef struct {
    int           n;
    bit           v;
    logic [287:0] w;
    bit           fd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        b_vin = 1'b0, s_vin = 1'b0;
  logic [31:0] b_din = '0, s_din = '0;
  logic [31:0] b_dout [0:8];
  logic [31:0] s_dout [0:8];
  logic        b_vo, b_fd, s_vo, s_fd;
  logic [287:0] b_win, s_win;
  logic        b_vin_q, s_vin_q;

  int tests = 0, fails = 0;
  int b_pulses = 0, b_fds = 0, s_pulses = 0, s_fds = 0;
  int tr [2];
  int tc [2];
  exp_t q_b [$];
  exp_t q_s [$];

  conv1_window_gen #(.DATA_WIDTH(32), .IMG_W(28), .IMG_H(28)) u_dut (
    .clk(clk), .rst(rst), .valid_in(b_vin), .data_in(b_din),
    .data_out(b_dout), .valid_out(b_vo), .frame_done(b_fd));

  conv1_window_gen #(.DATA_WIDTH(32), .IMG_W(5), .IMG_H(4)) u_small (
    .clk(clk), .rst(rst), .valid_in(s_vin), .data_in(s_din),
    .data_out(s_dout), .valid_out(s_vo), .frame_done(s_fd));

  always #5 clk = ~clk;

  always_comb begin
    b_win = '0;
    s_win = '0;
    for (int k = 0; k < 9; k++) begin
      b_win[k*32 +: 32] = b_dout[k];
      s_win[k*32 +: 32] = s_dout[k];
    end
  end

  always @(posedge clk) begin
    b_vin_q <= b_vin;
    s_vin_q <= s_vin;
  end

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [287:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {32'(a8), 32'(a7), 32'(a6), 32'(a5), 32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  // Reference window: pixel at (r,c) carries value base + r*W + c.
  function automatic logic [287:0] model_win(input int base, input int r, input int c, input int w);
    logic [287:0] v;
    v = '0;
    for (int k = 0; k < 9; k++)
      v[k*32 +: 32] = 32'(base + (r - 2 + k / 3) * w + (c - 2 + k % 3));
    return v;
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (b_vo) begin
        b_pulses++;
        if (b_fd) b_fds++;
        if (!b_vin_q) chk("big_valid_after_idle", 288'(b_vin_q), 288'(1));
        if (q_b.size() == 0) begin
          tests++; fails++;
          $display("FAIL big_unexpected_window: got %h expected no window", b_win);
        end else begin
          exp_t e;
          e = q_b.pop_front();
          chk("big_window", b_win, e.w);
          chk("big_frame_done", 288'(b_fd), 288'(e.fd));
        end
      end else if (b_fd) chk("big_fd_without_valid", 288'(b_fd), 288'(0));
      if (s_vo) begin
        s_pulses++;
        if (s_fd) s_fds++;
        if (q_s.size() == 0) begin
          tests++; fails++;
          $display("FAIL small_unexpected_window: got %h expected no window", s_win);
        end else begin
          exp_t e;
          e = q_s.pop_front();
          chk("small_window", s_win, e.w);
          chk("small_frame_done", 288'(s_fd), 288'(e.fd));
        end
      end else if (s_fd) chk("small_fd_without_valid", 288'(s_fd), 288'(0));
    end
  end

  // Drive one beat after `gap` idle cycles; push the expected window if one is due.
  task automatic send(input bit sm, input int base, input int gap);
    int w, h, r, c, pix;
    w = sm ? 5 : 28;
    h = sm ? 4 : 28;
    r = tr[sm];
    c = tc[sm];
    repeat (gap) begin @(posedge clk); #1; end
    pix = base + r * w + c;
    if (sm) begin s_vin = 1'b1; s_din = 32'(pix); end
    else    begin b_vin = 1'b1; b_din = 32'(pix); end
    if (r >= 2 && c >= 2) begin
      exp_t e;
      e.w  = model_win(base, r, c, w);
      e.fd = (r == h - 1) && (c == w - 1);
      if (sm) q_s.push_back(e); else q_b.push_back(e);
    end
    @(posedge clk); #1;
    b_vin = 1'b0;
    s_vin = 1'b0;
    if (c == w - 1) begin
      tc[sm] = 0;
      tr[sm] = (r == h - 1) ? 0 : r + 1;
    end else tc[sm] = c + 1;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t tab [7];
    int cnt;
    tr = '{0, 0};
    tc = '{0, 0};
    tab[0] = '{57,  1'b0, '0, 1'b0};
    tab[1] = '{58,  1'b1, w9(0, 1, 2, 28, 29, 30, 56, 57, 58), 1'b0};
    tab[2] = '{83,  1'b1, w9(25, 26, 27, 53, 54, 55, 81, 82, 83), 1'b0};
    tab[3] = '{84,  1'b0, '0, 1'b0};
    tab[4] = '{85,  1'b0, '0, 1'b0};
    tab[5] = '{86,  1'b1, w9(28, 29, 30, 56, 57, 58, 84, 85, 86), 1'b0};
    tab[6] = '{783, 1'b1, w9(725, 726, 727, 753, 754, 755, 781, 782, 783), 1'b1};

    #12;
    chk("reset_valid", 288'(b_vo), 288'(0));
    chk("reset_fd", 288'(b_fd), 288'(0));
    chk("reset_window", b_win, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Gapless frame with spot checks, then an immediate second frame.
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      while (cnt <= tab[i].n) begin send(1'b0, 0, 0); cnt++; end
      chk($sformatf("vec_valid_n%0d", tab[i].n), 288'(b_vo), 288'(tab[i].v));
      if (tab[i].v) begin
        chk($sformatf("vec_window_n%0d", tab[i].n), b_win, tab[i].w);
        chk($sformatf("vec_fd_n%0d", tab[i].n), 288'(b_fd), 288'(tab[i].fd));
      end
    end
    for (int n = 0; n < 784; n++) begin
      send(1'b0, 0, 0);
      if (n == 58) chk("frame2_first_window", b_win, w9(0, 1, 2, 28, 29, 30, 56, 57, 58));
    end
    settle();
    chk("two_frames_pulses", 288'(b_pulses), 288'(1352));
    chk("two_frames_fd", 288'(b_fds), 288'(2));
    chk("two_frames_queue_empty", 288'(q_b.size()), 288'(0));

    // Random valid_in duty with forced gaps at row and frame boundaries.
    b_pulses = 0; b_fds = 0;
    for (int n = 0; n < 784; n++) begin
      int gap;
      if (tc[0] == 0) gap = $urandom_range(1, 10);
      else gap = ($urandom_range(0, 99) < 70) ? 0 : int'($urandom_range(1, 10));
      send(1'b0, 5000, gap);
    end
    settle();
    chk("random_pulses", 288'(b_pulses), 288'(676));
    chk("random_fd", 288'(b_fds), 288'(1));
    chk("random_queue_empty", 288'(q_b.size()), 288'(0));

    // Mid-frame reset after beat 300, then a fresh frame.
    for (int n = 0; n <= 300; n++) send(1'b0, 9000, 0);
    rst = 1'b1;
    #2;
    chk("midrst_valid", 288'(b_vo), 288'(0));
    chk("midrst_fd", 288'(b_fd), 288'(0));
    chk("midrst_window", b_win, '0);
    q_b.delete();
    tr[0] = 0; tc[0] = 0;
    @(posedge clk); #1;
    chk("midrst_window_held", b_win, '0);
    rst = 1'b0;
    b_pulses = 0; b_fds = 0;
    for (int n = 0; n < 784; n++) begin
      send(1'b0, 0, 0);
      if (n == 57) chk("postrst_no_valid_58th", 288'(b_vo), 288'(0));
      if (n == 58) begin
        chk("postrst_valid_59th", 288'(b_vo), 288'(1));
        chk("postrst_first_window", b_win, w9(0, 1, 2, 28, 29, 30, 56, 57, 58));
      end
    end
    settle();
    chk("postrst_pulses", 288'(b_pulses), 288'(676));
    chk("postrst_fd", 288'(b_fds), 288'(1));

    // Small 5x4 frame.
    for (int n = 0; n < 20; n++) begin
      send(1'b1, 0, 0);
      if (n == 12) begin
        chk("small_first_valid", 288'(s_vo), 288'(1));
        chk("small_first_window", s_win, w9(0, 1, 2, 5, 6, 7, 10, 11, 12));
      end
      if (n == 19) begin
        chk("small_last_window", s_win, w9(7, 8, 9, 12, 13, 14, 17, 18, 19));
        chk("small_last_fd", 288'(s_fd), 288'(1));
      end
    end
    settle();
    chk("small_pulses", 288'(s_pulses), 288'(6));
    chk("small_fd_count", 288'(s_fds), 288'(1));
    chk("small_queue_empty", 288'(q_s.size()), 288'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
